// File: rtl/and_gate_arbiter.sv
// Round-robin arbiter time-sharing one external AND gate among NUM_REQ requesters.
// Latency: grant edge + GATE_LATENCY+1 edges to response; period GATE_LATENCY+3 cycles.
// Backpressure: requests are held until granted; req_in is ignored while busy. Optional AND_GATE_ARBITER_STATS_EN adds txn_count_out.
module and_gate_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 1,
    parameter int GATE_LATENCY = 1
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    input  logic [NUM_REQ-1:0]             req_in,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] a_req_in,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] b_req_in,
    output logic [NUM_REQ-1:0]             gnt_out,
    output logic [INPUT_WIDTH-1:0]         gate_a_out,
    output logic [INPUT_WIDTH-1:0]         gate_b_out,
    input  logic [INPUT_WIDTH:0]           gate_c_in,
    output logic [NUM_REQ-1:0]             rsp_valid_out,
    output logic [INPUT_WIDTH:0]           rsp_data_out,
    output logic                           busy_out
`ifdef AND_GATE_ARBITER_STATS_EN
    ,
    output logic [15:0]                    txn_count_out
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       winner_q, winner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [INPUT_WIDTH:0]   rsp_data_q, rsp_data_d;
    logic [INPUT_WIDTH-1:0] gate_a_q, gate_a_d;
    logic [INPUT_WIDTH-1:0] gate_b_q, gate_b_d;
    logic                   busy_q, busy_d;
`ifdef AND_GATE_ARBITER_STATS_EN
    logic [15:0]            txn_q, txn_d;
`endif

    logic                   found;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W:0]         idx_ext;
    logic [PTR_W-1:0]       idx;
    logic [INPUT_WIDTH-1:0] sel_a, sel_b;
    logic [NUM_REQ-1:0]     win_onehot, rsp_onehot;

    // Walk requesters starting at the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx_ext = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_ext = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (idx_ext >= (PTR_W+1)'(NUM_REQ)) begin
                idx_ext = idx_ext - (PTR_W+1)'(NUM_REQ);
            end
            idx = idx_ext[PTR_W-1:0];
            if (!found && req_in[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        win_onehot = '0;
        rsp_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                sel_a         = a_req_in[i*INPUT_WIDTH +: INPUT_WIDTH];
                sel_b         = b_req_in[i*INPUT_WIDTH +: INPUT_WIDTH];
                win_onehot[i] = 1'b1;
            end
            if (winner_q == PTR_W'(i)) begin
                rsp_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        gate_a_d    = gate_a_q;
        gate_b_d    = gate_b_q;
`ifdef AND_GATE_ARBITER_STATS_EN
        txn_d       = txn_q;
`endif
        case (state_q)
            IDLE: begin
                gate_a_d = '0;
                gate_b_d = '0;
                if (found) begin
                    winner_d = win_idx;
                    gate_a_d = sel_a;
                    gate_b_d = sel_b;
                    gnt_d    = win_onehot;
                    cnt_d    = CNT_W'(GATE_LATENCY);
                    if (win_idx == PTR_W'(NUM_REQ-1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx + 1'b1;
                    end
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Counter hits zero one edge after the gate result has settled.
                if (cnt_q == '0) begin
                    rsp_data_d  = gate_c_in;
                    rsp_valid_d = rsp_onehot;
                    gate_a_d    = '0;
                    gate_b_d    = '0;
                    state_d     = RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
`ifdef AND_GATE_ARBITER_STATS_EN
                if (txn_q != 16'hFFFF) begin
                    txn_d = txn_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d  = IDLE;
                gate_a_d = '0;
                gate_b_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            gate_a_q    <= '0;
            gate_b_q    <= '0;
            busy_q      <= 1'b0;
`ifdef AND_GATE_ARBITER_STATS_EN
            txn_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            gate_a_q    <= gate_a_d;
            gate_b_q    <= gate_b_d;
            busy_q      <= busy_d;
`ifdef AND_GATE_ARBITER_STATS_EN
            txn_q       <= txn_d;
`endif
        end
    end

    assign gnt_out       = gnt_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_data_out  = rsp_data_q;
    assign gate_a_out    = gate_a_q;
    assign gate_b_out    = gate_b_q;
    assign busy_out      = busy_q;
`ifdef AND_GATE_ARBITER_STATS_EN
    assign txn_count_out = txn_q;
`endif

endmodule

// File: tb/tb_and_gate_arbiter.sv
// Directed bench for and_gate_arbiter (NUM_REQ=4, INPUT_WIDTH=1, GATE_LATENCY=1).
module tb_and_gate_arbiter;

    localparam int N = 4;
    localparam int W = 1;
    localparam int L = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic [N-1:0] gnt;
    logic [W-1:0] gate_a, gate_b;
    logic [W:0]   gate_c;
    logic [N-1:0] rsp_valid;
    logic [W:0]   rsp_data;
    logic         busy;
`ifdef AND_GATE_ARBITER_STATS_EN
    logic [15:0]  txn_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared gate model: one-edge registered AND, zero-extended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) gate_c <= '0;
        else     gate_c <= {1'b0, gate_a & gate_b};
    end

    and_gate_arbiter #(
        .NUM_REQ(N), .INPUT_WIDTH(W), .GATE_LATENCY(L)
    ) dut (
        .clock_in      (clk),
        .reset_in      (rst),
        .req_in        (req),
        .a_req_in      (a_in),
        .b_req_in      (b_in),
        .gnt_out       (gnt),
        .gate_a_out    (gate_a),
        .gate_b_out    (gate_b),
        .gate_c_in     (gate_c),
        .rsp_valid_out (rsp_valid),
        .rsp_data_out  (rsp_data),
        .busy_out      (busy)
`ifdef AND_GATE_ARBITER_STATS_EN
        ,
        .txn_count_out (txn_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] gnt;
        logic [1:0] data;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        int n;
        n    = 0;
        req  = v.req;
        a_in = v.a;
        b_in = v.b;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 20);
        chk("gnt", 32'(gnt), 32'(v.gnt));
        chk("gnt_latency", n, 1);
        chk("busy_wait", 32'(busy), 1);
        chk("gate_a", 32'(gate_a), 32'(|(v.a & v.gnt)));
        chk("gate_b", 32'(gate_b), 32'(|(v.b & v.gnt)));
        req = '0;
        @(negedge clk);
        chk("gnt_pulse", 32'(gnt), 0);
        chk("gate_a_hold", 32'(gate_a), 32'(|(v.a & v.gnt)));
        chk("rsp_early", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(v.gnt));
        chk("rsp_data", 32'(rsp_data), 32'(v.data));
        chk("gate_a_respond", 32'(gate_a), 0);
        @(negedge clk);
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
        chk("rsp_data_hold", 32'(rsp_data), 32'(v.data));
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        logic [3:0] rr_exp[5];
        int gcount, last;
        bit saw_rsp;

        // req, a, b, expected grant, expected data; pointer tracked by hand
        vecs[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 2'b01}; // P 0->1
        vecs[1] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 2'b00}; // (1,0) P->0
        vecs[2] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 2'b00}; // (0,1)
        vecs[3] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'b00}; // (0,0)
        vecs[4] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 2'b01}; // (1,1)
        vecs[5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 2'b01}; // P->2
        vecs[6] = '{4'b0011, 4'b0011, 4'b0001, 4'b0001, 2'b01}; // wrap to 0, P->1
        vecs[7] = '{4'b0011, 4'b0011, 4'b0010, 4'b0010, 2'b01}; // P->2
        vecs[8] = '{4'b0101, 4'b0100, 4'b0100, 4'b0100, 2'b01}; // P->3
        vecs[9] = '{4'b0101, 4'b0101, 4'b0000, 4'b0001, 2'b00}; // wrap to 0

        #2;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_data", 32'(rsp_data), 0);
        chk("reset_gate_a", 32'(gate_a), 0);
        chk("reset_busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end
`ifdef AND_GATE_ARBITER_STATS_EN
        chk("txn_count", 32'(txn_count), 10);
`endif

        // All requesters held high from reset: strict rotation, 4-cycle spacing.
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst  = 1'b1;
        req  = 4'b1111;
        a_in = 4'b1111;
        b_in = 4'b1111;
        @(negedge clk);
        rst    = 1'b0;
        gcount = 0;
        last   = 0;
        for (int c = 0; c < 40 && gcount < 5; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                chk("rr_gnt", 32'(gnt), 32'(rr_exp[gcount]));
                if (gcount > 0) chk("rr_spacing", c - last, 4);
                last = c;
                gcount++;
            end
        end
        chk("rr_count", gcount, 5);

        // Reset asserted mid-WAIT: outputs clear without a clock, transaction is dropped.
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'(4'b0001));
        req = '0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_gate_a", 32'(gate_a), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_gate_a", 32'(gate_a), 0);
        chk("async_gate_b", 32'(gate_b), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        rst     = 1'b0;
        saw_rsp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) saw_rsp = 1'b1;
        end
        chk("no_rsp_after_reset", 32'(saw_rsp), 0);
        req = 4'b1111;
        @(negedge clk);
        chk("post_reset_gnt", 32'(gnt), 32'(4'b0001));
        req = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_gate_arbiter.md
AND_GATE_ARBITER -- requirements
Module: and_gate_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters sharing one my_and_gate instance (legal 2..8).
REQ-002 Parameter INPUT_WIDTH, default 1, meaning operand width passed to the shared gate.
REQ-003 Parameter GATE_LATENCY, default 1, meaning edges from gate operand change to valid gate result (legal 1..15).
REQ-004 clock_in  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset_in  input  1  asynchronous, active-high reset.
REQ-006 req_in  input  NUM_REQ  per-requester request, held high until granted.
REQ-007 a_req_in  input  NUM_REQ*INPUT_WIDTH  operand A, requester i in slice i.
REQ-008 b_req_in  input  NUM_REQ*INPUT_WIDTH  operand B, requester i in slice i.
REQ-009 gnt_out  output  NUM_REQ  one-hot grant pulse, one cycle.
REQ-010 gate_a_out  output  INPUT_WIDTH  operand A to the shared gate.
REQ-011 gate_b_out  output  INPUT_WIDTH  operand B to the shared gate.
REQ-012 gate_c_in  input  INPUT_WIDTH+1  result from the shared gate.
REQ-013 rsp_valid_out  output  NUM_REQ  one-hot response-valid pulse, one cycle.
REQ-014 rsp_data_out  output  INPUT_WIDTH+1  captured result, qualified by rsp_valid_out.
REQ-015 busy_out  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESPOND; all outputs registered.
REQ-017 IDLE: at an edge with any req_in high, the arbiter SHALL select one requester, latch its operands onto gate_a_out/gate_b_out, pulse gnt_out for that requester in the following cycle, load the wait counter with GATE_LATENCY, and enter WAIT.
REQ-018 Selection SHALL be round-robin: search starts at pointer P, first set req_in bit at or above P (wrapping) wins; P SHALL become winner+1 mod NUM_REQ at grant.
REQ-019 WAIT: counter SHALL decrement each edge; at the edge where counter is 0 (GATE_LATENCY+1 edges after the grant edge), gate_c_in SHALL be captured into rsp_data_out and state SHALL go to RESPOND.
REQ-020 RESPOND: rsp_valid_out SHALL be high for exactly the winner for one cycle; next edge SHALL return to IDLE.
REQ-021 gate_a_out/gate_b_out SHALL hold the latched operands through WAIT and be driven to 0 in IDLE and RESPOND.
REQ-022 req_in SHALL be ignored outside IDLE; a requester still high in IDLE after its grant is a new request.
REQ-023 rsp_data_out SHALL hold its last value when rsp_valid_out is low.
REQ-024 Transaction period SHALL be exactly GATE_LATENCY+3 cycles grant-to-next-grant under continuous requests.

Reset
REQ-025 reset_in high SHALL immediately force state IDLE, P=0, counter 0, and all outputs to 0, independent of clock_in.
REQ-026 Reset mid-transaction SHALL drop the in-flight transaction with no rsp_valid_out pulse; first post-reset grant SHALL follow REQ-018 with P=0.

Configuration
REQ-027 Macro AND_GATE_ARBITER_STATS_EN defined: output port txn_count_out (16 bits) SHALL count completed RESPOND cycles, saturating at 0xFFFF, cleared by reset.
REQ-028 Macro undefined: port txn_count_out and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Single request: req_in=0001, a=1, b=1, GATE_LATENCY=1 -> gnt_out=0001 one cycle, gate_a/b=1/1 for 2 cycles, rsp_valid_out=0001 with rsp_data_out=01 two cycles after gnt.
REQ-030 All requesters held high from reset -> grants 0001,0010,0100,1000,0001 spaced exactly 4 cycles apart.
REQ-031 P=2 after grant to 1, req_in=0011 -> next grant to requester 0 (wrap), P becomes 1.
REQ-032 reset_in pulsed in WAIT -> all outputs 0 asynchronously, no rsp_valid_out, next req_in=1111 grants requester 0.
REQ-033 Operands (a,b)=(0,0),(1,0),(0,1),(1,1) from requester 3 -> rsp_data_out 00,00,00,01 respectively.
REQ-034 With AND_GATE_ARBITER_STATS_EN, 5 completed transactions -> txn_count_out=5; without macro, bench compiles without the port.
